// File: rtl/phase_cmd_ctrl.sv
// Byte-stream command controller: decodes 4-byte frames into double-buffered
// per-channel phase offsets and duty values. Optional ACK responses: PHASE_CMD_ACK_EN.
module phase_cmd_ctrl #(
  parameter int CHANNELS     = 88,
  parameter int OFFSET_WIDTH = 11,
  parameter int DUTY_WIDTH   = 8,
  parameter int DUTY_RESET   = 2**(DUTY_WIDTH-1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       rx_data,
  input  logic                             rx_valid,
  output logic                             rx_ready,
  output logic [7:0]                       tx_data,
  output logic                             tx_valid,
  input  logic                             tx_ready,
  output logic [CHANNELS*OFFSET_WIDTH-1:0] offsets,
  output logic [CHANNELS*DUTY_WIDTH-1:0]   duty,
  output logic                             reload,
  output logic                             frame_err
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int VAL_W = (OFFSET_WIDTH > DUTY_WIDTH) ? OFFSET_WIDTH : DUTY_WIDTH;
  localparam logic [13:0] CH_COUNT = 14'(CHANNELS);
  localparam logic [7:0]  NAK_BYTE = 8'h7F;
  localparam logic [7:0]  ACK_BYTE = 8'h06;
`ifdef PHASE_CMD_ACK_EN
  localparam logic [1:0]  WR_RESP_LEN = 2'd1;
`else
  localparam logic [1:0]  WR_RESP_LEN = 2'd0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EXEC    = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  state_t state_r, state_s;
  logic [1:0] cnt_r, cnt_s;

  logic [2:0]       op_r;
  logic [10:0]      chan_r;
  logic [6:0]       val_hi_r;
  logic [VAL_W-1:0] val_r;

  logic [OFFSET_WIDTH-1:0] off_shd_r  [CHANNELS];
  logic [OFFSET_WIDTH-1:0] off_act_r  [CHANNELS];
  logic [DUTY_WIDTH-1:0]   duty_shd_r [CHANNELS];
  logic [DUTY_WIDTH-1:0]   duty_act_r [CHANNELS];

  logic       rx_ready_r, tx_valid_r, reload_r, frame_err_r;
  logic [7:0] tx_data_r;
  logic [7:0] resp_b1_r;
  logic       resp_more_r;

  logic       rx_ready_s, tx_valid_s, reload_s, frame_err_s, resp_more_s;
  logic [7:0] tx_data_s, resp_b1_s;

  logic             acc_s, sync_s, chan_ok_s;
  logic [IDX_W-1:0] idx_s;
  logic [1:0]       ex_len_s;
  logic [7:0]       ex_b0_s, ex_b1_s;
  logic             ex_err_s, ex_wr_off_s, ex_wr_duty_s, ex_commit_s;
  logic [13:0]      rb_val_s;

  assign acc_s     = rx_valid && rx_ready_r;
  assign sync_s    = rx_data[7];
  assign idx_s     = chan_r[IDX_W-1:0];
  assign chan_ok_s = (32'(chan_r) < 32'(CHANNELS));

  // Decode the collected frame into its effect and response bytes
  always_comb begin
    ex_len_s     = 2'd0;
    ex_b0_s      = 8'h00;
    ex_b1_s      = 8'h00;
    ex_err_s     = 1'b0;
    ex_wr_off_s  = 1'b0;
    ex_wr_duty_s = 1'b0;
    ex_commit_s  = 1'b0;
    rb_val_s     = 14'd0;
    case (op_r)
      3'd0, 3'd1: begin
        if (chan_ok_s) begin
          ex_wr_off_s  = (op_r == 3'd0);
          ex_wr_duty_s = (op_r == 3'd1);
          ex_len_s     = WR_RESP_LEN;
          ex_b0_s      = ACK_BYTE;
        end else begin
          ex_len_s = 2'd1;
          ex_b0_s  = NAK_BYTE;
          ex_err_s = 1'b1;
        end
      end
      3'd2: begin
        ex_commit_s = 1'b1;
        ex_len_s    = WR_RESP_LEN;
        ex_b0_s     = ACK_BYTE;
      end
      3'd3: begin
        ex_len_s = 2'd2;
        ex_b0_s  = {1'b0, CH_COUNT[13:7]};
        ex_b1_s  = {1'b0, CH_COUNT[6:0]};
      end
      3'd4, 3'd5: begin
        if (chan_ok_s) begin
          rb_val_s = (op_r == 3'd4) ? 14'(off_act_r[idx_s]) : 14'(duty_act_r[idx_s]);
          ex_len_s = 2'd2;
          ex_b0_s  = {1'b0, rb_val_s[13:7]};
          ex_b1_s  = {1'b0, rb_val_s[6:0]};
        end else begin
          ex_len_s = 2'd1;
          ex_b0_s  = NAK_BYTE;
          ex_err_s = 1'b1;
        end
      end
      default: begin
        ex_len_s = 2'd1;
        ex_b0_s  = NAK_BYTE;
        ex_err_s = 1'b1;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic; a sync byte inside a frame restarts collection
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (acc_s && sync_s) begin
          state_s = ST_COLLECT;
          cnt_s   = 2'd1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (acc_s) begin
          if (sync_s) begin
            cnt_s = 2'd1;
          end else if (cnt_r == 2'd3) begin
            state_s = ST_EXEC;
          end else begin
            cnt_s = cnt_r + 2'd1;
          end
        end else begin
          state_s = ST_COLLECT;
        end
      end
      ST_EXEC: state_s = (ex_len_s != 2'd0) ? ST_RESP : ST_IDLE;
      ST_RESP: begin
        if (tx_ready && !resp_more_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and the response queue
  always_comb begin
    rx_ready_s  = (state_s == ST_IDLE) || (state_s == ST_COLLECT);
    reload_s    = (state_r == ST_EXEC) && ex_commit_s;
    frame_err_s = ((state_r == ST_IDLE) && acc_s && !sync_s) ||
                  ((state_r == ST_COLLECT) && acc_s && sync_s) ||
                  ((state_r == ST_EXEC) && ex_err_s);
    tx_valid_s  = tx_valid_r;
    tx_data_s   = tx_data_r;
    resp_b1_s   = resp_b1_r;
    resp_more_s = resp_more_r;
    case (state_r)
      ST_EXEC: begin
        tx_valid_s  = (ex_len_s != 2'd0);
        tx_data_s   = ex_b0_s;
        resp_b1_s   = ex_b1_s;
        resp_more_s = (ex_len_s == 2'd2);
      end
      ST_RESP: begin
        if (tx_ready) begin
          if (resp_more_r) begin
            tx_data_s   = resp_b1_r;
            resp_more_s = 1'b0;
          end else begin
            tx_valid_s = 1'b0;
          end
        end else begin
          tx_valid_s = tx_valid_r;
        end
      end
      default: begin
        tx_valid_s = tx_valid_r;
      end
    endcase
  end

  // Output registers, frame capture and the shadow/active register banks
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ready_r  <= 1'b0;
      tx_valid_r  <= 1'b0;
      tx_data_r   <= 8'h00;
      reload_r    <= 1'b0;
      frame_err_r <= 1'b0;
      resp_b1_r   <= 8'h00;
      resp_more_r <= 1'b0;
      op_r        <= 3'd0;
      chan_r      <= 11'd0;
      val_hi_r    <= 7'd0;
      val_r       <= {VAL_W{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
        off_shd_r[i]  <= {OFFSET_WIDTH{1'b0}};
        off_act_r[i]  <= {OFFSET_WIDTH{1'b0}};
        duty_shd_r[i] <= DUTY_WIDTH'(DUTY_RESET);
        duty_act_r[i] <= DUTY_WIDTH'(DUTY_RESET);
      end
    end else begin
      rx_ready_r  <= rx_ready_s;
      tx_valid_r  <= tx_valid_s;
      tx_data_r   <= tx_data_s;
      reload_r    <= reload_s;
      frame_err_r <= frame_err_s;
      resp_b1_r   <= resp_b1_s;
      resp_more_r <= resp_more_s;
      if (acc_s && sync_s) begin
        op_r         <= rx_data[6:4];
        chan_r[10:7] <= rx_data[3:0];
      end else if (acc_s && (state_r == ST_COLLECT)) begin
        case (cnt_r)
          2'd1:    chan_r[6:0] <= rx_data[6:0];
          2'd2:    val_hi_r    <= rx_data[6:0];
          2'd3:    val_r       <= VAL_W'({val_hi_r, rx_data[6:0]});
          default: val_r       <= val_r;
        endcase
      end
      if (state_r == ST_EXEC) begin
        if (ex_wr_off_s) begin
          off_shd_r[idx_s] <= val_r[OFFSET_WIDTH-1:0];
        end
        if (ex_wr_duty_s) begin
          duty_shd_r[idx_s] <= val_r[DUTY_WIDTH-1:0];
        end
        if (ex_commit_s) begin
          off_act_r  <= off_shd_r;
          duty_act_r <= duty_shd_r;
        end
      end
    end
  end

  assign rx_ready  = rx_ready_r;
  assign tx_valid  = tx_valid_r;
  assign tx_data   = tx_data_r;
  assign reload    = reload_r;
  assign frame_err = frame_err_r;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign offsets[OFFSET_WIDTH*g +: OFFSET_WIDTH] = off_act_r[g];
    assign duty[DUTY_WIDTH*g +: DUTY_WIDTH]        = duty_act_r[g];
  end

endmodule

// File: tb/tb_phase_cmd_ctrl.sv
// Randomized self-checking bench for phase_cmd_ctrl with a frame-level reference model.
module tb_phase_cmd_ctrl;
  localparam int CH = 88;
  localparam int OW = 11;
  localparam int DW = 8;
  localparam int DR = 128;
`ifdef PHASE_CMD_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic clk, rst;
  logic [7:0] rx_data, tx_data;
  logic rx_valid, rx_ready, tx_valid, tx_ready, reload, frame_err;
  logic [CH*OW-1:0] offsets;
  logic [CH*DW-1:0] duty;

  phase_cmd_ctrl #(.CHANNELS(CH), .OFFSET_WIDTH(OW), .DUTY_WIDTH(DW), .DUTY_RESET(DR)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .offsets(offsets),
    .duty(duty), .reload(reload), .frame_err(frame_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model
  int m_off_shd[CH], m_off_act[CH], m_duty_shd[CH], m_duty_act[CH];
  logic [7:0] exp_q[$];
  logic [7:0] send_q[$];
  logic [7:0] got_q[$];
  int exp_err, exp_rel;
  bit err_known;

  int err_cnt = 0;
  int reload_cnt = 0;
  bit hold_ready = 1'b1;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_off_shd[i] = 0; m_off_act[i] = 0; m_duty_shd[i] = DR; m_duty_act[i] = DR;
    end
  endtask

  task automatic model_apply(input int op, input int chan, input int val);
    bit ok;
    int v;
    ok = (chan < CH);
    exp_q.delete(); exp_err = 0; exp_rel = 0; err_known = 1'b1;
    case (op)
      0, 1: begin
        if (ok) begin
          if (op == 0) m_off_shd[chan] = val % (1 << OW);
          else m_duty_shd[chan] = val % (1 << DW);
          if (ACK) exp_q.push_back(8'h06);
        end else begin
          exp_q.push_back(8'h7F); exp_err = 1;
        end
      end
      2: begin
        for (int i = 0; i < CH; i++) begin
          m_off_act[i] = m_off_shd[i]; m_duty_act[i] = m_duty_shd[i];
        end
        exp_rel = 1;
        if (ACK) exp_q.push_back(8'h06);
      end
      3: begin
        exp_q.push_back(8'(CH / 128)); exp_q.push_back(8'(CH % 128));
      end
      4, 5: begin
        if (ok) begin
          v = (op == 4) ? m_off_act[chan] : m_duty_act[chan];
          exp_q.push_back(8'(v / 128)); exp_q.push_back(8'(v % 128));
        end else begin
          exp_q.push_back(8'h7F); exp_err = 1;
        end
      end
      default: begin
        exp_q.push_back(8'h7F); err_known = 1'b0;
      end
    endcase
  endtask

  task automatic build_frame(input int op, input int chan, input int val);
    logic [2:0] ob; logic [10:0] cb; logic [13:0] vb;
    ob = 3'(op); cb = 11'(chan); vb = 14'(val);
    send_q.delete();
    send_q.push_back({1'b1, ob, cb[10:7]});
    send_q.push_back({1'b0, cb[6:0]});
    send_q.push_back({1'b0, vb[13:7]});
    send_q.push_back({1'b0, vb[6:0]});
  endtask

  function automatic logic [1023:0] exp_offsets();
    logic [1023:0] r = '0;
    for (int i = 0; i < CH; i++) r[OW*i +: OW] = OW'(m_off_act[i]);
    return r;
  endfunction

  function automatic logic [1023:0] exp_duty();
    logic [1023:0] r = '0;
    for (int i = 0; i < CH; i++) r[DW*i +: DW] = DW'(m_duty_act[i]);
    return r;
  endfunction

  // transmitter side: random back-pressure, byte capture, hold-stability check
  initial begin
    bit stalled = 1'b0;
    logic [7:0] last_data = 8'h00;
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      err_cnt += int'(frame_err);
      reload_cnt += int'(reload);
      if (stalled && tx_valid) check("tx_hold", tx_data, last_data);
      tx_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      stalled = tx_valid && !tx_ready;
      last_data = tx_data;
    end
  end

  int e0, r0;

  task automatic send_bytes(input string tag);
    int guard;
    got_q.delete();
    e0 = err_cnt; r0 = reload_cnt;
    foreach (send_q[k]) begin
      guard = 0;
      while (!rx_ready && guard < 200) begin @(negedge clk); guard++; end
      if (!rx_ready) check({tag, "_rx_wait"}, rx_ready, 1'b1);
      rx_data = send_q[k];
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic finish_frame(input string tag);
    int guard = 0;
    while (!rx_ready && guard < 500) begin @(negedge clk); guard++; end
    check({tag, "_idle"}, rx_ready, 1'b1);
    @(negedge clk);
    check({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, got_q[i], exp_q[i]);
    if (err_known) check({tag, "_frame_err"}, err_cnt - e0, exp_err);
    check({tag, "_reload"}, reload_cnt - r0, exp_rel);
    check({tag, "_offsets"}, offsets, exp_offsets());
    check({tag, "_duty"}, duty, exp_duty());
  endtask

  task automatic do_frame(input string tag, input int op, input int chan, input int val);
    model_apply(op, chan, val);
    build_frame(op, chan, val);
    send_bytes(tag);
    finish_frame(tag);
  endtask

  initial begin
    int guard;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_reload", reload, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_offsets", offsets, exp_offsets());
    check("rst_duty", duty, exp_duty());
    rst = 1'b0;
    hold_ready = 1'b0;
    @(negedge clk);

    // out-of-range write is rejected, commit then leaves reset values
    do_frame("range_wr", 0, 88, 1);
    do_frame("range_commit", 2, 0, 0);

    // shadow write invisible until commit
    do_frame("wr5", 0, 5, 16'h03FF);
    do_frame("commit5", 2, 0, 0);

    // query with transmitter stalled for 10 cycles
    hold_ready = 1'b1;
    model_apply(3, 0, 0);
    build_frame(3, 0, 0);
    send_bytes("query");
    guard = 0;
    while (!tx_valid && guard < 50) begin @(negedge clk); guard++; end
    check("query_tx_valid", tx_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("query_hold_data", tx_data, exp_q[0]);
      check("query_hold_rx_ready", rx_ready, 1'b0);
    end
    hold_ready = 1'b0;
    finish_frame("query");

    // resync on a sync byte mid-frame
    model_apply(1, 0, 16'h0082);
    exp_err += 1;
    send_q = '{8'h80, 8'h05, 8'h90, 8'h00, 8'h01, 8'h02};
    send_bytes("resync");
    finish_frame("resync");
    do_frame("resync_commit", 2, 0, 0);

    // stray payload byte in idle
    exp_q.delete(); exp_err = 1; exp_rel = 0; err_known = 1'b1;
    send_q = '{8'h12};
    send_bytes("stray");
    finish_frame("stray");

    // readback of channel 87
    do_frame("wr87", 0, 87, 16'h0123);
    do_frame("commit87", 2, 0, 0);
    do_frame("rb_off87", 4, 87, 0);
    do_frame("rb_duty87", 5, 87, 0);

    // random traffic
    for (int n = 0; n < 200; n++) begin
      int op, chan, val;
      op = $urandom_range(0, 7);
      chan = ($urandom_range(0, 9) == 0) ? $urandom_range(88, 2047) : $urandom_range(0, 87);
      val = $urandom_range(0, 16383);
      do_frame("rand", op, chan, val);
    end
    do_frame("rand_commit", 2, 0, 0);

    // reset in the middle of a response
    hold_ready = 1'b1;
    model_apply(3, 0, 0);
    build_frame(3, 0, 0);
    send_bytes("rst_mid");
    guard = 0;
    while (!tx_valid && guard < 50) begin @(negedge clk); guard++; end
    check("rst_mid_tx_valid_pre", tx_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    check("rst_mid_tx_valid", tx_valid, 1'b0);
    check("rst_mid_rx_ready", rx_ready, 1'b0);
    check("rst_mid_offsets", offsets, exp_offsets());
    check("rst_mid_duty", duty, exp_duty());
    rst = 1'b0;
    hold_ready = 1'b0;
    @(negedge clk);
    check("rst_mid_idle", rx_ready, 1'b1);
    do_frame("post_rst_wr", 0, 3, 16'h0055);
    do_frame("post_rst_commit", 2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/phase_cmd_ctrl.md
# phase_cmd_ctrl

Byte-stream command controller for the transducer phase array. It sits between the UART AXI-stream byte interface and the bank of per-channel clock generators. It decodes 4-byte framed commands into double-buffered per-channel phase offsets and duty values. A commit copies all shadow values to the active outputs atomically and pulses a reload strobe. It answers query commands over the byte stream.

## Interface
- CHANNELS, 88, number of transducer channels (1..2048)
- OFFSET_WIDTH, 11, bits per phase offset (1..14)
- DUTY_WIDTH, 8, bits per duty value (1..14)
- DUTY_RESET, 2**(DUTY_WIDTH-1), reset value of every shadow and active duty
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx_data  input  8  received byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  controller accepts a byte this cycle
- tx_data  output  8  response byte
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  transmitter accepts tx_data
- offsets  output  CHANNELS*OFFSET_WIDTH  active offsets; channel i at [OFFSET_WIDTH*i +: OFFSET_WIDTH]
- duty  output  CHANNELS*DUTY_WIDTH  active duty values, same packing
- reload  output  1  one-cycle high pulse on commit
- frame_err  output  1  one-cycle high pulse on a dropped or rejected frame

## Operation
- Frame: byte0 has bit7=1: [6:4] opcode, [3:0] chan[10:7]. Bytes 1..3 have bit7=0: byte1[6:0] chan[6:0]; byte2[6:0] val[13:7]; byte3[6:0] val[6:0].
- Value truncation: a write stores val[OFFSET_WIDTH-1:0] or val[DUTY_WIDTH-1:0]. Upper bits are ignored.
- States: IDLE, COLLECT(count 1..3), EXEC, RESP.
  - IDLE: a bit7=1 byte goes to COLLECT. A bit7=0 byte is dropped and pulses frame_err.
  - COLLECT: a bit7=1 byte restarts the frame with that byte as byte0 and pulses frame_err. The third payload byte goes to EXEC.
  - EXEC: one cycle. It goes to RESP if the response queue is non-empty, otherwise to IDLE.
  - RESP: presents the queued bytes in order, then returns to IDLE.
- Opcodes:
  - 0: write the shadow offset of chan.
  - 1: write the shadow duty of chan.
  - 2: commit. Copies all shadows to the active outputs and pulses reload. Chan and val are ignored.
  - 3: query. Responds {0,CHANNELS[13:7]}, {0,CHANNELS[6:0]}.
  - 4: readback. Responds the active offset of chan as {0,v[13:7]}, {0,v[6:0]}, zero-extended.
  - 5: readback. Same as opcode 4 for the active duty of chan.
  - 6, 7: NAK.
- Range check: opcodes 0, 1, 4 and 5 with chan ≥ CHANNELS respond NAK, pulse frame_err and leave all state unchanged.
- NAK byte: 0x7F.
- Shadow writes never change the offsets or duty outputs before a commit.

## Timing
- Reset values:
  - rx_ready=0, tx_valid=0, tx_data=0, reload=0, frame_err=0, state IDLE.
  - All offsets (shadow and active) = 0.
  - All duty values (shadow and active) = DUTY_RESET.
- Byte acceptance:
  - A byte is accepted on an edge with rx_valid&&rx_ready.
  - rx_ready is 1 in IDLE and COLLECT.
  - rx_ready is 0 in EXEC and RESP, and in the cycle after the edge that accepts byte3.
- Write and commit latency: byte3 is accepted at edge N and EXEC executes at edge N+1.
  - Shadow writes are done after N+1.
  - For a commit, the active outputs change and reload=1 after N+1, for one cycle only.
- Response latency: tx_valid rises after edge N+1.
  - tx_data is held stable while tx_valid=1 and !tx_ready.
  - On an edge with tx_ready, the next queued byte is presented in the following cycle, or tx_valid drops.
  - tx_ready may be held low indefinitely, and the controller stalls in RESP.
- frame_err is high for exactly one cycle after the offending edge.
- A bit7=1 byte accepted in COLLECT counts as byte0 in the same cycle. No byte is lost.
- Reset asserted mid-frame or mid-response: all state returns to reset values on the next edge. A pending response is discarded.
- Back-to-back frames: a new byte0 is accepted at the earliest in the cycle after RESP/EXEC returns to IDLE.

## Configuration
- PHASE_CMD_ACK_EN:
  - Defined: opcodes 0, 1 and 2 on success respond a single ACK byte 0x06, queued in EXEC like any other response.
  - Not defined: these opcodes produce no response, and EXEC returns directly to IDLE.
  - NAK and query behaviour are identical either way.

## Test plan
- Write shadow offset: channel 5, val 0x3FF (bytes 0x80,0x05,0x07,0x7F). offsets[5] stays 0. A commit (0xA0,0,0,0) then gives offsets[5]=0x3FF, reload high for exactly one cycle, and all other channels unchanged.
- Query: 0xB0,0,0,0 → responds 0x00, 0x58 (CHANNELS=88). Hold tx_ready low 10 cycles: tx_data holds 0x00 and rx_ready stays 0.
- Range check: write to channel 88 (0x80,0x58,0,1) → NAK 0x7F, frame_err pulses once, and a subsequent commit leaves all outputs at their reset values.
- Resync: 0x80,0x05,0x90,0x00,0x01,0x02 → frame_err pulses once. Shadow duty of channel 0 becomes 0x82 (DUTY_WIDTH=8) and commits on the next opcode 2. Separately, a stray 0x12 sent in IDLE is dropped and pulses frame_err.
- Readback: after committing offset 0x123 to channel 87, opcode 4 for channel 87 → responds 0x02, 0x23. Opcode 5 for channel 87 → responds 0x01, 0x00 (DUTY_RESET=0x80).
- Reset mid-response: assert rst while tx_valid=1 → next cycle tx_valid=0, offsets=0, duty=0x80 and state IDLE. With PHASE_CMD_ACK_EN defined, the first write after reset responds 0x06.
